// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundles every write-back signal between the producers (ALU, long-latency
// unit), the issue-logic query port and the register file.
//
// Handshake: the LSU result moves when lsu_valid and lsu_ready are both high
// at a posedge. lsu_ready never depends on lsu_valid. The ALU has no
// back-pressure: a live ALU result is always consumed in its own cycle.
//
// Signals:
//   alu_valid/alu_addr/alu_data : single-cycle pipeline result
//   lsu_valid/lsu_ready/lsu_addr/lsu_data : long-latency result handshake
//   wrd/addr_d/d                : registered regfile write port
//   query_addr/query_hit        : pending-write lookup for issue logic
// Modports: slave = arbiter side, master = environment side.
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 alu_valid;
  logic [4:0]           alu_addr;
  logic [DataWidth-1:0] alu_data;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [4:0]           lsu_addr;
  logic [DataWidth-1:0] lsu_data;
  logic                 wrd;
  logic [4:0]           addr_d;
  logic [DataWidth-1:0] d;
  logic [4:0]           query_addr;
  logic                 query_hit;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  query_addr,
    output lsu_ready, wrd, addr_d, d, query_hit
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output query_addr,
    input  lsu_ready, wrd, addr_d, d, query_hit
  );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges the single-cycle ALU result and a long-latency (load/mul/div) result
// onto one registered regfile write port. The ALU always wins; LSU results
// that lose are parked in a small FIFO and drained in order whenever the ALU
// is quiet. A younger ALU write squashes older parked writes to the same
// register (WAW) so they drain as no-ops.
//
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-high reset
//   bus   : wb_arbiter_if.slave (see interface file for signal list)
// Parameters:
//   DataWidth : write-back data width
//   DEPTH     : buffer capacity, power of two >= 2
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DataWidth = 32,
  parameter int DEPTH     = 2
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Buffer storage and pointers
  logic [4:0]           buf_addr_q [DEPTH];
  logic [4:0]           buf_addr_d [DEPTH];
  logic [DataWidth-1:0] buf_data_q [DEPTH];
  logic [DataWidth-1:0] buf_data_d [DEPTH];
  logic                 buf_sq_q   [DEPTH];
  logic                 buf_sq_d   [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q,  count_d;

  // Output stage
  logic                 wrd_q,    wrd_d;
  logic [4:0]           addr_q,   addr_d;
  logic [DataWidth-1:0] data_q,   data_d;

  logic alu_live;
  logic lsu_acc;
  logic pop;
  logic push;
  logic bypass;

  assign alu_live      = bus.alu_valid && (bus.alu_addr != 5'd0);
  assign bus.lsu_ready = (count_q < FULL);
  assign lsu_acc       = bus.lsu_valid && bus.lsu_ready;

  // Priority: live ALU, then buffer head, then direct LSU bypass.
  assign pop    = !alu_live && (count_q != '0);
  assign bypass = !alu_live && (count_q == '0) && lsu_acc;
  assign push   = lsu_acc && !bypass;

  always_comb begin
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    buf_sq_d   = buf_sq_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wrd_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    // WAW: the ALU result is younger than anything parked in the buffer.
    if (alu_live) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (buf_addr_q[i] == bus.alu_addr) buf_sq_d[i] = 1'b1;
      end
    end

    if (alu_live) begin
      wrd_d  = 1'b1;
      addr_d = bus.alu_addr;
      data_d = bus.alu_data;
    end else if (pop) begin
      // Squashed or x0 entries occupy a drain slot but write nothing.
      if (!buf_sq_q[rd_ptr_q] && (buf_addr_q[rd_ptr_q] != 5'd0)) begin
        wrd_d  = 1'b1;
        addr_d = buf_addr_q[rd_ptr_q];
        data_d = buf_data_q[rd_ptr_q];
      end
      buf_sq_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PW'(1);
    end else if (bypass) begin
      if (bus.lsu_addr != 5'd0) begin
        wrd_d  = 1'b1;
        addr_d = bus.lsu_addr;
        data_d = bus.lsu_data;
      end
    end

    if (push) begin
      buf_addr_d[wr_ptr_q] = bus.lsu_addr;
      buf_data_d[wr_ptr_q] = bus.lsu_data;
      buf_sq_d[wr_ptr_q]   = alu_live && (bus.lsu_addr == bus.alu_addr);
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_addr_q[i] <= '0;
        buf_data_q[i] <= '0;
        buf_sq_q[i]   <= 1'b0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wrd_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      buf_sq_q   <= buf_sq_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wrd_q      <= wrd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign bus.wrd    = wrd_q;
  assign bus.addr_d = addr_q;
  assign bus.d      = data_q;

  // Pending-write lookup: occupied unsquashed slots, the output stage, and
  // whatever is being accepted this very cycle.
  logic          buf_hit;
  logic [PW-1:0] offset;

  always_comb begin
    buf_hit = 1'b0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if (({1'b0, offset} < count_q) && !buf_sq_q[i] &&
          (buf_addr_q[i] == bus.query_addr)) begin
        buf_hit = 1'b1;
      end
    end
  end

  assign bus.query_hit = (bus.query_addr != 5'd0) &&
                         (buf_hit ||
                          (wrd_q && (addr_q == bus.query_addr)) ||
                          (alu_live && (bus.alu_addr == bus.query_addr)) ||
                          (lsu_acc && (bus.lsu_addr == bus.query_addr)));

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Bench for wb_arbiter: directed scenarios with literal expectations followed
// by randomized traffic, all compared each cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DataWidth(DW)) bus();

  wb_arbiter #(.DataWidth(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- model / scoreboard ----------------
  typedef struct {
    logic [4:0]    addr;
    logic [DW-1:0] data;
    bit            sq;
  } ent_t;

  ent_t          mq[$];
  bit            m_wrd;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_d;
  logic [DW-1:0] rf_dut [32];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.alu_valid  = 1'b0;
    bus.alu_addr   = '0;
    bus.alu_data   = '0;
    bus.lsu_valid  = 1'b0;
    bus.lsu_addr   = '0;
    bus.lsu_data   = '0;
    bus.query_addr = '0;
  endtask

  task automatic drive_alu(input bit v, input logic [4:0] a, input logic [DW-1:0] dd);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = dd;
  endtask

  task automatic drive_lsu(input bit v, input logic [4:0] a, input logic [DW-1:0] dd);
    bus.lsu_valid = v;
    bus.lsu_addr  = a;
    bus.lsu_data  = dd;
  endtask

  // One clock cycle: inputs were set just after the previous posedge.
  // Checks combinational outputs mid-cycle, advances the model, then checks
  // the registered outputs just after the edge.
  task automatic cycle();
    bit   live, acc, hit, ready;
    ent_t e;
    #1;
    ready = (mq.size() < DEPTH);
    live  = bus.alu_valid && (bus.alu_addr != 0);
    acc   = bus.lsu_valid && ready;
    hit   = 1'b0;
    if (bus.query_addr != 0) begin
      foreach (mq[i]) if (!mq[i].sq && mq[i].addr == bus.query_addr) hit = 1'b1;
      if (m_wrd && m_addr == bus.query_addr) hit = 1'b1;
      if (live && bus.alu_addr == bus.query_addr) hit = 1'b1;
      if (acc && bus.lsu_addr == bus.query_addr) hit = 1'b1;
    end
    check("lsu_ready", bus.lsu_ready, ready);
    check("query_hit", bus.query_hit, hit);

    if (live) begin
      foreach (mq[i]) if (mq[i].addr == bus.alu_addr) mq[i].sq = 1'b1;
      m_wrd = 1'b1; m_addr = bus.alu_addr; m_d = bus.alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wrd = !e.sq && (e.addr != 0);
      if (m_wrd) begin m_addr = e.addr; m_d = e.data; end
    end else if (acc) begin
      m_wrd = (bus.lsu_addr != 0);
      if (m_wrd) begin m_addr = bus.lsu_addr; m_d = bus.lsu_data; end
      acc = 1'b0;  // consumed by bypass, nothing to park
    end else begin
      m_wrd = 1'b0;
    end
    if (acc) begin
      e.addr = bus.lsu_addr;
      e.data = bus.lsu_data;
      e.sq   = live && (bus.lsu_addr == bus.alu_addr);
      mq.push_back(e);
    end

    @(posedge clk);
    #1;
    check("wrd", bus.wrd, m_wrd);
    if (m_wrd) begin
      check("addr_d", bus.addr_d, m_addr);
      check("d", bus.d, m_d);
    end
    if (bus.wrd === 1'b1) rf_dut[bus.addr_d] = bus.d;
  endtask

  // Asserts reset asynchronously mid-cycle and releases it after one edge.
  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    #1;
    check("rst_wrd", bus.wrd, 1'b0);
    check("rst_addr_d", bus.addr_d, 5'd0);
    check("rst_d", bus.d, '0);
    check("rst_lsu_ready", bus.lsu_ready, 1'b1);
    mq.delete();
    m_wrd = 1'b0; m_addr = '0; m_d = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] seq [5];
    for (int i = 0; i < 32; i++) rf_dut[i] = '0;
    set_idle();
    do_reset();

    // Single ALU write, then idle.
    drive_alu(1, 5'd5, 32'h11);
    cycle();
    check("t1_wrd", bus.wrd, 1'b1);
    check("t1_addr", bus.addr_d, 5'd5);
    check("t1_d", bus.d, 32'h11);
    set_idle();
    cycle();
    check("t1_wrd_off", bus.wrd, 1'b0);

    // ALU busy three cycles while LSU fills the buffer.
    seq[0] = 5'd1; seq[1] = 5'd2; seq[2] = 5'd3; seq[3] = 5'd7; seq[4] = 5'd8;
    drive_alu(1, 5'd1, 32'h101); drive_lsu(1, 5'd7, 32'hA);
    cycle();
    check("t2_addr0", bus.addr_d, seq[0]);
    drive_alu(1, 5'd2, 32'h102); drive_lsu(1, 5'd8, 32'hB);
    cycle();
    check("t2_addr1", bus.addr_d, seq[1]);
    drive_alu(1, 5'd3, 32'h103); drive_lsu(0, 5'd0, '0);
    #1;
    check("t2_full_ready", bus.lsu_ready, 1'b0);
    cycle();
    check("t2_addr2", bus.addr_d, seq[2]);
    set_idle();
    cycle();
    check("t2_wrd3", bus.wrd, 1'b1);
    check("t2_addr3", bus.addr_d, seq[3]);
    check("t2_d3", bus.d, 32'hA);
    cycle();
    check("t2_wrd4", bus.wrd, 1'b1);
    check("t2_addr4", bus.addr_d, seq[4]);
    check("t2_d4", bus.d, 32'hB);

    // Bypass with the buffer empty.
    drive_lsu(1, 5'd9, 32'hCAFE);
    cycle();
    check("t3_wrd", bus.wrd, 1'b1);
    check("t3_addr", bus.addr_d, 5'd9);
    check("t3_d", bus.d, 32'hCAFE);
    set_idle();
    #1;
    check("t3_ready", bus.lsu_ready, 1'b1);
    cycle();

    // WAW squash of a parked result.
    drive_alu(1, 5'd1, 32'h55); drive_lsu(1, 5'd4, 32'h1);
    cycle();
    drive_alu(1, 5'd4, 32'h2); drive_lsu(0, 5'd0, '0);
    bus.query_addr = 5'd4;
    cycle();
    check("t4_wrd", bus.wrd, 1'b1);
    check("t4_d", bus.d, 32'h2);
    set_idle();
    bus.query_addr = 5'd4;
    cycle();
    check("t4_pop_wrd", bus.wrd, 1'b0);
    check("t4_x4", rf_dut[4], 32'h2);

    // LSU x0 while idle.
    set_idle();
    drive_lsu(1, 5'd0, 32'hDEAD);
    #1;
    check("t5_hit", bus.query_hit, 1'b0);
    cycle();
    check("t5_wrd", bus.wrd, 1'b0);
    set_idle();
    cycle();

    // Reset with the buffer full.
    drive_alu(1, 5'd10, 32'h1); drive_lsu(1, 5'd11, 32'h2);
    cycle();
    drive_alu(1, 5'd12, 32'h3); drive_lsu(1, 5'd13, 32'h4);
    cycle();
    #1;
    check("t6_full", bus.lsu_ready, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_no_write", bus.wrd, 1'b0);
    end

    // Randomized traffic over a small register range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        drive_alu($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom);
        drive_lsu($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
        bus.query_addr = 5'($urandom_range(0, 7));
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
